mul_booth_pipe: RTL

Three-stage pipelined 32×32 multiplier core for the EX/MEM path. It supports signed and unsigned MULT/MULTU, MUL, MADD/MADDU and MSUB/MSUBU. It sign- or zero-extends the operands and builds 17 radix-4 Booth partial products. It then compresses them, together with an optional HI/LO accumulate operand, through a carry-save tree and produces a 64-bit result three cycles after issue. It sits between the ID/EX operand latch and the HI/LO register file / MEM writeback mux.

---
 rtl/mul_pkg.sv | 21 ++
 rtl/booth2.sv | 35 +++
 rtl/mul_booth_pipe.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared widths and types for the pipelined radix-4 Booth multiplier.
package mul_pkg;

  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned PP_NUM  = 17;
  localparam int unsigned PP_W    = 64;
  localparam int unsigned OPX_W   = 33;
  localparam int unsigned OPY_W   = 34;
  localparam int unsigned OP_W    = 32;
  localparam int unsigned OP_NUM  = PP_NUM + 1;
  localparam int unsigned CSA_LVL = 6;

  typedef logic [PP_NUM-1:0][PP_W-1:0] pp_arr_t;
  typedef logic [OP_NUM-1:0][PP_W-1:0] ops_t;

  typedef struct packed {
    logic [PP_W-1:0] sum;
    logic [PP_W-1:0] carry;
  } csa_t;

endpackage

// File: rtl/booth2.sv
// Radix-4 Booth partial-product selector; optional negation folds MSUB into the product.
module booth2
  import mul_pkg::*;
(
  input  logic [OPX_W-1:0] x,
  input  logic [2:0]       y,
  input  logic             is_msub,
  output logic [PP_W-1:0]  z
);

  logic [PP_W-1:0] w_xe;
  logic [PP_W-1:0] w_mag;
  logic            w_neg;

  always_comb begin
    w_mag = '0;
    w_neg = 1'b0;
    w_xe  = {{(PP_W-OPX_W){x[OPX_W-1]}}, x};
    unique case (y)
      3'b001, 3'b010: w_mag = w_xe;
      3'b011:         w_mag = {w_xe[PP_W-2:0], 1'b0};
      3'b100: begin
        w_mag = {w_xe[PP_W-2:0], 1'b0};
        w_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        w_mag = w_xe;
        w_neg = 1'b1;
      end
      default: w_mag = '0;
    endcase
    z = (w_neg ^ is_msub) ? PP_W'(-w_mag) : w_mag;
  end

endmodule

// File: rtl/mul_booth_pipe.sv
// Three-stage 32x32 Booth multiplier with HI/LO accumulate for MULT/MUL/MADD/MSUB.
module mul_booth_pipe
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_signed,
  input  logic              is_acc,
  input  logic              is_msub,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PP_W-1:0]   hilo_i,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [PP_W-1:0]   result_o,
  output logic              busy
);

  // Wallace-style 3:2 reduction, 18 -> 12 -> 8 -> 6 -> 4 -> 3 -> 2 operands.
  function automatic csa_t csa_tree(input ops_t ops);
    ops_t            cur;
    ops_t            nxt;
    logic [PP_W-1:0] p0, p1, p2, maj;
    int              n, m, base;
    csa_t            res;
    cur = ops;
    n   = int'(OP_NUM);
    for (int lvl = 0; lvl < int'(CSA_LVL); lvl++) begin
      nxt = '0;
      m   = 0;
      for (int k = 0; k < int'(OP_NUM) / 3; k++) begin
        if (3 * k + 2 < n) begin
          p0  = cur[5'(3 * k)];
          p1  = cur[5'(3 * k + 1)];
          p2  = cur[5'(3 * k + 2)];
          maj = (p0 & p1) | (p0 & p2) | (p1 & p2);
          nxt[5'(m)]     = p0 ^ p1 ^ p2;
          nxt[5'(m + 1)] = {maj[PP_W-2:0], 1'b0};
          m = m + 2;
        end
      end
      base = 3 * (n / 3);
      for (int k = 0; k < 2; k++) begin
        if (base + k < n) begin
          nxt[5'(m)] = cur[5'(base + k)];
          m = m + 1;
        end
      end
      cur = nxt;
      n   = m;
    end
    res.sum   = cur[0];
    res.carry = cur[1];
    return res;
  endfunction

  logic [OPX_W-1:0] w_x;
  logic [OPY_W-1:0] w_y;
  logic [OPY_W:0]   w_yw;
  logic             w_neg;
  logic [PP_W-1:0]  w_addend;
  pp_arr_t          w_z;
  pp_arr_t          w_pp;
  ops_t             w_ops;
  csa_t             w_csa;

  pp_arr_t          r_pp;
  logic [PP_W-1:0]  r_addend;
  logic [PP_W-1:0]  r_sum;
  logic [PP_W-1:0]  r_carry;
  logic [PP_W-1:0]  r_result;
  logic             r_v1;
  logic             r_v2;
  logic             r_v3;

  assign w_x      = {is_signed & a[OP_W-1], a};
  assign w_y      = {{2{is_signed & b[OP_W-1]}}, b};
  assign w_yw     = {w_y, 1'b0};
  assign w_neg    = is_msub & is_acc;
  assign w_addend = is_acc ? hilo_i : '0;

  for (genvar gi = 0; gi < int'(PP_NUM); gi++) begin : g_pp
    booth2 u_booth2 (
      .x       (w_x),
      .y       (w_yw[2*gi+2 -: 3]),
      .is_msub (w_neg),
      .z       (w_z[gi])
    );
    assign w_pp[gi] = w_z[gi] << (2 * gi);
  end

  assign w_ops = {r_addend, r_pp};
  assign w_csa = csa_tree(w_ops);

  // Flush clears valid bits ahead of stall; data registers may keep stale values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pp     <= '0;
      r_addend <= '0;
      r_sum    <= '0;
      r_carry  <= '0;
      r_result <= '0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
    end else if (flush) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (!stall) begin
      r_pp     <= w_pp;
      r_addend <= w_addend;
      r_v1     <= in_valid;
      r_sum    <= w_csa.sum;
      r_carry  <= w_csa.carry;
      r_v2     <= r_v1;
      r_result <= r_sum + r_carry;
      r_v3     <= r_v2;
    end
  end

  assign in_ready  = !stall;
  assign out_valid = r_v3;
  assign result_o  = r_result;
  assign busy      = r_v1 | r_v2 | r_v3;

endmodule
